// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: fetch queue entry layout plus the issue-stage state
// and bundle types.
package cpu_defs;

  localparam int unsigned FETCH_NUM = 2;
  localparam int unsigned ISSUE_NUM = 2;

  typedef enum logic [2:0] {
    ControlFlow_None,
    ControlFlow_Branch,
    ControlFlow_Jump,
    ControlFlow_JumpReg,
    ControlFlow_Call,
    ControlFlow_Return
  } controlflow_t;

  typedef struct packed {
    logic         taken;
    controlflow_t cf;
    logic [31:0]  target;
  } branch_predict_t;

  typedef struct packed {
    logic       valid;
    logic       tlb_miss;
    logic [4:0] exc_code;
  } addr_ex_t;

  typedef struct packed {
    logic            valid;
    logic [31:0]     vaddr;
    logic [31:0]     instr;
    branch_predict_t branch_predict;
    addr_ex_t        iaddr_ex;
  } fetch_entry_t;

  typedef logic [1:0] fetch_ack_t;

  typedef enum logic {
    ISSUE_RUN,
    ISSUE_WAIT_DS
  } issue_state_t;

  typedef struct packed {
    logic         valid;
    logic         is_ds;
    fetch_entry_t entry;
  } issue_bundle_t;

  function automatic logic is_branch(input fetch_entry_t e);
    return e.branch_predict.cf != ControlFlow_None;
  endfunction

endpackage

// File: rtl/instr_issue_stage_pair.sv
// MIPS pairing rules for the two fetch-queue heads: how many issue this cycle,
// which slot is a delay slot, and whether a branch is waiting for its delay slot.
module issue_pair_logic
  import cpu_defs::*;
(
  input  fetch_entry_t e0_i,
  input  fetch_entry_t e1_i,
  output fetch_ack_t   take_o,
  output logic [1:0]   isDs_o,
  output logic         waitDs_o
);

  // A branch in slot 1 is held back so it can pair with its delay slot next cycle.
  always_comb begin
    take_o   = 2'd0;
    isDs_o   = 2'b00;
    waitDs_o = 1'b0;
    if (!e0_i.valid) begin
      take_o = 2'd0;
    end else if (e0_i.iaddr_ex.valid) begin
      take_o = 2'd1;
    end else if (is_branch(e0_i)) begin
      if (e1_i.valid) begin
        take_o = 2'd2;
        isDs_o = 2'b10;
      end else begin
        waitDs_o = 1'b1;
      end
    end else if (e1_i.valid && !e1_i.iaddr_ex.valid && !is_branch(e1_i)) begin
      take_o = 2'd2;
    end else begin
      take_o = 2'd1;
    end
  end

endmodule

// File: rtl/instr_issue_stage.sv
// Issue stage: pairs fetch-queue heads into bundles of up to two and registers them.
// Optional delay-slot wait counter enabled by defining ISSUE_HOLD_CNT_EN.
module instr_issue_stage
  import cpu_defs::*;
#(
  parameter int unsigned ISSUE_NUM = 2
`ifdef ISSUE_HOLD_CNT_EN
  , parameter int unsigned HOLD_CNT_WIDTH = 16
`endif
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush_i,
  input  logic                          stall_i,
  input  fetch_entry_t [FETCH_NUM-1:0]  fetch_entry_i,
  output fetch_ack_t                    fetch_ack_o,
  output logic [ISSUE_NUM-1:0]          issue_valid_o,
  output fetch_entry_t [ISSUE_NUM-1:0]  issue_entry_o,
  output logic [ISSUE_NUM-1:0]          issue_is_ds_o
`ifdef ISSUE_HOLD_CNT_EN
  , output logic [HOLD_CNT_WIDTH-1:0]   hold_count_o
`endif
);

  if (ISSUE_NUM != 2) begin : gBadIssueNum
    $error("instr_issue_stage supports only ISSUE_NUM == 2");
  end

  issue_state_t                  state_q, state_d;
  issue_bundle_t [ISSUE_NUM-1:0] bundle_q, bundle_d;
  fetch_ack_t                    take, takeEff;
  logic [1:0]                    isDs;
  logic                          waitDs;

  issue_pair_logic uPair (
    .e0_i     (fetch_entry_i[0]),
    .e1_i     (fetch_entry_i[1]),
    .take_o   (take),
    .isDs_o   (isDs),
    .waitDs_o (waitDs)
  );

  assign takeEff     = (state_q == ISSUE_WAIT_DS && !fetch_entry_i[1].valid) ? 2'd0 : take;
  assign fetch_ack_o = (!rst_n || stall_i || flush_i) ? 2'd0 : takeEff;

  always_comb begin
    state_d  = state_q;
    bundle_d = bundle_q;
    if (flush_i) begin
      state_d = ISSUE_RUN;
      for (int i = 0; i < ISSUE_NUM; i++) begin
        bundle_d[i].valid = 1'b0;
        bundle_d[i].is_ds = 1'b0;
      end
    end else if (!stall_i) begin
      state_d = waitDs ? ISSUE_WAIT_DS : ISSUE_RUN;
      for (int i = 0; i < ISSUE_NUM; i++) begin
        bundle_d[i].valid = (i < int'(takeEff));
        bundle_d[i].is_ds = isDs[i];
        bundle_d[i].entry = fetch_entry_i[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ISSUE_RUN;
      bundle_q <= '0;
    end else begin
      state_q  <= state_d;
      bundle_q <= bundle_d;
    end
  end

  for (genvar gi = 0; gi < ISSUE_NUM; gi++) begin : gOut
    assign issue_valid_o[gi] = bundle_q[gi].valid;
    assign issue_is_ds_o[gi] = bundle_q[gi].is_ds;
    assign issue_entry_o[gi] = bundle_q[gi].entry;
  end

`ifdef ISSUE_HOLD_CNT_EN
  localparam logic [HOLD_CNT_WIDTH-1:0] HoldOne = 1;
  logic [HOLD_CNT_WIDTH-1:0] holdCount_q, holdCount_d;

  // Counts waiting cycles that the stage actually spends idle, saturating at all-ones.
  always_comb begin
    holdCount_d = holdCount_q;
    if (waitDs && !stall_i && !flush_i && holdCount_q != '1)
      holdCount_d = holdCount_q + HoldOne;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) holdCount_q <= '0;
    else        holdCount_q <= holdCount_d;
  end

  assign hold_count_o = holdCount_q;
`endif

endmodule

// File: tb/tb_instr_issue_stage.sv
// Self-checking bench for instr_issue_stage: table vectors, hand sequences for
// delay-slot wait and reset, then a randomized program stream against a model.
module tb_instr_issue_stage;
  import cpu_defs::*;

  localparam int K_NONE = 0;
  localparam int K_ALU  = 1;
  localparam int K_BR   = 2;
  localparam int K_JR   = 3;
  localparam int K_EXC  = 4;

  typedef struct {
    int         k0;
    int         k1;
    bit         st;
    bit         fl;
    int         expAck;
    logic [1:0] expValid;
    logic [1:0] expDs;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic stall = 1'b0;
  fetch_entry_t [FETCH_NUM-1:0] fetchEntry;
  fetch_ack_t                   fetchAck;
  logic [1:0]                   issueValid;
  fetch_entry_t [1:0]           issueEntry;
  logic [1:0]                   issueIsDs;
`ifdef ISSUE_HOLD_CNT_EN
  logic [15:0] holdCount;
  int          expHold = 0;
`endif

  int checks = 0;
  int errors = 0;

  logic [1:0]  expValid = 2'b00;
  logic [1:0]  expDs = 2'b00;
  logic [31:0] expVa0 = '0;
  logic [31:0] expVa1 = '0;
  int          lastExpAck = 0;
  int          sampledAck = 0;

  always #5 clk = ~clk;

  instr_issue_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush_i       (flush),
    .stall_i       (stall),
    .fetch_entry_i (fetchEntry),
    .fetch_ack_o   (fetchAck),
    .issue_valid_o (issueValid),
    .issue_entry_o (issueEntry),
    .issue_is_ds_o (issueIsDs)
`ifdef ISSUE_HOLD_CNT_EN
    , .hold_count_o (holdCount)
`endif
  );

  function automatic fetch_entry_t mkEntry(input int kind, input logic [31:0] va);
    fetch_entry_t e;
    e = '0;
    e.valid = (kind != K_NONE);
    e.vaddr = va;
    e.instr = 32'h00851020;
    case (kind)
      K_BR: begin e.instr = 32'h10850004; e.branch_predict.cf = ControlFlow_Branch; end
      K_JR: begin e.instr = 32'h03e00008; e.branch_predict.cf = ControlFlow_JumpReg; end
      K_EXC: begin e.iaddr_ex.valid = 1'b1; e.iaddr_ex.exc_code = 5'd4; end
      default: ;
    endcase
    return e;
  endfunction

  // Pairing rules stated directly on the two queue heads.
  function automatic int specTake(input fetch_entry_t e0, input fetch_entry_t e1);
    bit b0 = (e0.branch_predict.cf != ControlFlow_None);
    bit b1 = (e1.branch_predict.cf != ControlFlow_None);
    if (!e0.valid) return 0;
    if (e0.iaddr_ex.valid) return 1;
    if (b0) return e1.valid ? 2 : 0;
    if (e1.valid && !e1.iaddr_ex.valid && !b1) return 2;
    return 1;
  endfunction

  task automatic checkOutput(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic checkRegs();
    checkOutput("issue_valid", issueValid, expValid);
    checkOutput("issue_is_ds", issueIsDs & issueValid, expDs & expValid);
    if (expValid[0]) checkOutput("slot0_vaddr", issueEntry[0].vaddr, expVa0);
    if (expValid[1]) checkOutput("slot1_vaddr", issueEntry[1].vaddr, expVa1);
`ifdef ISSUE_HOLD_CNT_EN
    checkOutput("hold_count", holdCount, expHold);
`endif
  endtask

  // Drives one cycle of inputs, checks the combinational ack, clocks, checks registers.
  task automatic applyStimulus(input fetch_entry_t e0, input fetch_entry_t e1,
                               input bit st, input bit fl);
    int tk;
    fetchEntry[0] = e0;
    fetchEntry[1] = e1;
    stall = st;
    flush = fl;
    #1;
    tk = specTake(e0, e1);
    lastExpAck = (st || fl) ? 0 : tk;
    sampledAck = int'(fetchAck);
    checkOutput("fetch_ack", fetchAck, lastExpAck);
`ifdef ISSUE_HOLD_CNT_EN
    if (e0.valid && !e0.iaddr_ex.valid && e0.branch_predict.cf != ControlFlow_None &&
        !e1.valid && !st && !fl && expHold < 65535)
      expHold++;
`endif
    @(posedge clk);
    if (fl) begin
      expValid = 2'b00;
      expDs = 2'b00;
    end else if (!st) begin
      expValid = (tk == 2) ? 2'b11 : (tk == 1) ? 2'b01 : 2'b00;
      expDs = (tk == 2 && e0.branch_predict.cf != ControlFlow_None) ? 2'b10 : 2'b00;
      expVa0 = e0.vaddr;
      expVa1 = e1.vaddr;
    end
    #1;
    checkRegs();
  endtask

  task automatic stepExpect(input int k0, input int k1, input bit st, input bit fl,
                            input int eAck, input logic [1:0] eValid, input logic [1:0] eDs,
                            input logic [31:0] va);
    applyStimulus(mkEntry(k0, va), mkEntry(k1, va + 32'd4), st, fl);
    checkOutput("vec_ack", sampledAck, eAck);
    checkOutput("vec_valid", issueValid, eValid);
    checkOutput("vec_ds", issueIsDs & issueValid, eDs);
  endtask

  vec_t vecs[13];
  fetch_entry_t prog[$];

  initial begin
    vecs[0]  = '{K_ALU,  K_ALU,  0, 0, 2, 2'b11, 2'b00};
    vecs[1]  = '{K_ALU,  K_BR,   0, 0, 1, 2'b01, 2'b00};
    vecs[2]  = '{K_BR,   K_ALU,  0, 0, 2, 2'b11, 2'b10};
    vecs[3]  = '{K_EXC,  K_ALU,  0, 0, 1, 2'b01, 2'b00};
    vecs[4]  = '{K_ALU,  K_EXC,  0, 0, 1, 2'b01, 2'b00};
    vecs[5]  = '{K_JR,   K_NONE, 0, 0, 0, 2'b00, 2'b00};
    vecs[6]  = '{K_JR,   K_ALU,  0, 0, 2, 2'b11, 2'b10};
    vecs[7]  = '{K_NONE, K_NONE, 0, 0, 0, 2'b00, 2'b00};
    vecs[8]  = '{K_ALU,  K_ALU,  0, 0, 2, 2'b11, 2'b00};
    vecs[9]  = '{K_ALU,  K_ALU,  1, 0, 0, 2'b11, 2'b00};
    vecs[10] = '{K_BR,   K_ALU,  1, 1, 0, 2'b00, 2'b00};
    vecs[11] = '{K_ALU,  K_NONE, 0, 0, 1, 2'b01, 2'b00};
    vecs[12] = '{K_BR,   K_BR,   0, 0, 2, 2'b11, 2'b10};

    // Reset state, with valid heads present while reset is held.
    fetchEntry[0] = mkEntry(K_ALU, 32'hBFC00000);
    fetchEntry[1] = mkEntry(K_ALU, 32'hBFC00004);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_valid", issueValid, 2'b00);
    checkOutput("reset_ds", issueIsDs, 2'b00);
    checkOutput("reset_entry0", issueEntry[0], 0);
    checkOutput("reset_ack", fetchAck, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++)
      stepExpect(vecs[i].k0, vecs[i].k1, vecs[i].st, vecs[i].fl, vecs[i].expAck,
                 vecs[i].expValid, vecs[i].expDs, 32'hBFC00000 + 32'(i * 8));

    // Asynchronous reset with a full bundle registered and a branch waiting.
    stepExpect(K_ALU, K_ALU, 0, 0, 2, 2'b11, 2'b00, 32'hBFC00100);
    fetchEntry[0] = mkEntry(K_JR, 32'hBFC00108);
    fetchEntry[1] = mkEntry(K_NONE, 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_valid", issueValid, 2'b00);
    checkOutput("async_reset_ack", fetchAck, 0);
    expValid = 2'b00;
    expDs = 2'b00;
`ifdef ISSUE_HOLD_CNT_EN
    expHold = 0;
    checkOutput("async_reset_hold", holdCount, 0);
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    stepExpect(K_NONE, K_NONE, 0, 0, 0, 2'b00, 2'b00, 32'hBFC00200);
    stepExpect(K_ALU, K_ALU, 0, 0, 2, 2'b11, 2'b00, 32'hBFC00200);

    // Jump register waiting three cycles for its delay slot.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(mkEntry(K_JR, 32'hBFC00300), mkEntry(K_NONE, 32'h0), 0, 0);
      checkOutput("wait_ack", sampledAck, 0);
      checkOutput("wait_valid", issueValid, 2'b00);
    end
`ifdef ISSUE_HOLD_CNT_EN
    checkOutput("wait_hold3", holdCount, 3);
`endif
    stepExpect(K_JR, K_ALU, 0, 0, 2, 2'b11, 2'b10, 32'hBFC00300);
    checkOutput("ds_vaddr", issueEntry[1].vaddr, 32'hBFC00304);

    // Randomized program stream; entries leave the queue only through fetch_ack.
    for (int i = 0; i < 400; i++) begin
      int r;
      int k;
      r = $urandom_range(0, 99);
      k = (r < 60) ? K_ALU : (r < 75) ? K_BR : (r < 82) ? K_JR : (r < 92) ? K_EXC : K_ALU;
      prog.push_back(mkEntry(k, 32'hBFC10000 + 32'(i * 4)));
    end
    prog.push_back(mkEntry(K_ALU, 32'hBFC20000));
    prog.push_back(mkEntry(K_ALU, 32'hBFC20004));
    begin
      int avail = 0;
      for (int cyc = 0; cyc < 3000 && prog.size() > 0; cyc++) begin
        fetch_entry_t e0;
        fetch_entry_t e1;
        avail += $urandom_range(0, 2);
        if (avail > prog.size()) avail = prog.size();
        e0 = (avail >= 1) ? prog[0] : mkEntry(K_NONE, 32'h0);
        e1 = (avail >= 2) ? prog[1] : mkEntry(K_NONE, 32'h0);
        applyStimulus(e0, e1, $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 5);
        for (int k = 0; k < lastExpAck; k++) begin
          void'(prog.pop_front());
          avail--;
        end
      end
    end
    checkOutput("stream_drained", prog.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_issue_stage.md
Name: instr_issue_stage

Overview:
- Stage directly downstream of instruction fetch.
- Consumes the `FETCH_NUM` head entries of the fetch queue (`fetch_entry`) and forms issue bundles of up to 2 instructions under MIPS pairing rules.
- Registers each bundle into the fetch/decode pipeline register and returns the consumed count through `fetch_ack`.
- Pairing rules: a branch and its delay slot issue in the same bundle; a fetch-exception entry issues alone.

Parameters:
- ISSUE_NUM, 2, bundle width; only 2 is supported, elaboration error otherwise.
- HOLD_CNT_WIDTH, 16, width of the delay-slot wait counter (optional feature).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  pipeline flush (exception or mispredict); kills the registered bundle and the current consume
- stall  in  1  downstream cannot accept; output register holds
- fetch_entry  in  FETCH_NUM x fetch_entry_t  queue heads in program order; .valid qualifies each
- fetch_ack  out  fetch_ack_t  entries consumed this cycle (0..2); combinational
- issue_valid  out  ISSUE_NUM  per-slot valid of the registered bundle
- issue_entry  out  ISSUE_NUM x fetch_entry_t  registered bundle (vaddr, instr, branch_predict, iaddr_ex)
- issue_is_ds  out  ISSUE_NUM  slot holds a delay slot of the preceding slot
- hold_count  out  HOLD_CNT_WIDTH  only present when the optional feature is compiled in

Behaviour:
- Reset: issue_valid=0, issue_entry='0, issue_is_ds=0, state=RUN; fetch_ack=0 while rst_n is low.
- Branch test: `fetch_entry[i].branch_predict.cf != ControlFlow_None`.
- Exception test: `fetch_entry[i].iaddr_ex.valid`.
- `take` (combinational, 0..2), evaluated on e0=`fetch_entry[0]`, e1=`fetch_entry[1]`:
  - e0 invalid -> 0.
  - e0 exception -> 1.
  - e0 branch and e1 valid -> 2; set `issue_is_ds[1]`.
  - e0 branch and e1 invalid -> 0; next state WAIT_DS.
  - e0 non-branch, e1 valid, e1 not exception, e1 not branch -> 2.
  - Otherwise -> 1. A branch in slot 1 is deferred so it pairs with its delay slot next cycle.
- States: RUN and WAIT_DS.
  - WAIT_DS -> RUN when e1 becomes valid (bundle of 2 issues that cycle) or on flush.
  - In WAIT_DS, take is 0.
- Consume rules:
  - `fetch_ack = (stall | flush) ? 0 : take`.
  - Queue entries are removed only via `fetch_ack`.
- Output register, updated at posedge:
  - flush -> issue_valid=0, state=RUN. Flush has priority over stall.
  - else stall -> hold all outputs unchanged.
  - else load slot i with valid=(i < take) and the entry. Slots >= take are loaded invalid with data don't-care.
- Latency: 1 cycle from queue head to issue_entry. Full throughput of 2 per cycle with no bubbles for non-branch streams.
- Flush during WAIT_DS: the pending branch is not issued, fetch_ack stays 0, state returns to RUN.
- Reset asserted mid-operation clears all state asynchronously. No partial bundle survives.

Optional Feature:
- Macro: `ISSUE_HOLD_CNT_EN`.
- Defined:
  - Saturating counter `hold_count` increments every cycle spent in WAIT_DS while not stalled.
  - Clears on reset only.
  - Output port present.
- Undefined: no counter and no port; behaviour otherwise identical.

Decomposition:
- Shared package `cpu_defs` gets:
  - `issue_state_t` enum {ISSUE_RUN, ISSUE_WAIT_DS}
  - `ISSUE_NUM` constant
  - `issue_bundle_t` struct {valid, is_ds, entry}
- Reuses `fetch_entry_t`, `fetch_ack_t` and `controlflow_t` from the package.
- One natural sub-module: `issue_pair_logic`, holding the combinational take/is_ds computation. Register and FSM stay in the top module.

Test Plan:
- Two ALU instrs at 0xBFC00000/04, stall=0 -> fetch_ack=2; next cycle issue_valid=2'b11, vaddrs 0xBFC00000/04.
- e0 ALU, e1 BEQ at 0x..04 -> ack=1; next cycle BEQ at e0, delay slot at e1 -> ack=2, issue_is_ds=2'b10.
- e0 JR, e1 invalid for 3 cycles -> ack=0 for 3 cycles, state WAIT_DS, hold_count=3 with `ISSUE_HOLD_CNT_EN`; e1 arrives -> ack=2, state RUN.
- e0 with iaddr_ex.valid, e1 valid ALU -> ack=1, issue_valid=2'b01.
- stall=1 with valid heads -> ack=0 and outputs frozen; flush asserted together with stall -> issue_valid=0 next cycle.
- rst_n dropped while in WAIT_DS -> issue_valid=0 immediately, state RUN, ack=0 after release until heads are valid.
